// File: rtl/can_pkg.sv
`default_nettype none
// ============================================================================
// Module   : can_pkg
// Brief    : Shared CAN frame types, field widths and CRC polynomial.
// Revision : 1.0 - initial release
// ============================================================================
package can_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SOF  = 3'd1,
        ARB  = 3'd2,
        CTRL = 3'd3,
        DATA = 3'd4,
        CRC  = 3'd5,
        ACK  = 3'd6,
        EOF  = 3'd7
    } can_rx_state_t;

    localparam int ID_BITS    = 11;
    localparam int CTRL_BITS  = 7;
    localparam int DATA_BITS  = 32;
    localparam int CRC_BITS   = 15;
    localparam int FRAME_BITS = 68;

    localparam logic [14:0] CRC_POLY_CAN = 15'h4599;

endpackage
`default_nettype wire

// File: rtl/can_frame_rx_if.sv
`default_nettype none
// ============================================================================
// Module   : can_frame_rx_if
// Brief    : CAN line pins plus received-frame bus of the frame receiver.
// Revision : 1.0 - initial release
// ============================================================================
interface can_frame_rx_if;
    import can_pkg::*;

    logic                 can_rx;
    logic                 can_tx;
    logic [ID_BITS-1:0]   rx_id;
    logic [CTRL_BITS-1:0] rx_ctrl;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_error;
    logic                 busy;

    modport master (
        input  can_rx,
        output can_tx, rx_id, rx_ctrl, rx_data, rx_valid, rx_error, busy
    );

    modport slave (
        output can_rx,
        input  can_tx, rx_id, rx_ctrl, rx_data, rx_valid, rx_error, busy
    );

endinterface
`default_nettype wire

// File: rtl/can_crc15.sv
`default_nettype none
// ============================================================================
// Module   : can_crc15
// Brief    : Serial CAN CRC-15 generator, one bit per shift_en.
// Revision : 1.0 - initial release
// ============================================================================
module can_crc15
    import can_pkg::*;
#(
    parameter logic [14:0] POLY = CRC_POLY_CAN
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        clear,
    input  logic        shift_en,
    input  logic        din,
    output logic [14:0] crc
);

    logic [14:0] r_crc;
    logic        w_nxt;

    assign w_nxt = din ^ r_crc[14];

    always_ff @(posedge clk) begin
        if (!n_rst || clear) begin
            r_crc <= '0;
        end else if (shift_en) begin
            r_crc <= {r_crc[13:0], 1'b0} ^ (w_nxt ? POLY : 15'd0);
        end
    end

    assign crc = r_crc;

endmodule
`default_nettype wire

// File: rtl/can_frame_rx.sv
`default_nettype none
// ============================================================================
// Module   : can_frame_rx
// Brief    : Fixed 68-bit CAN frame deserializer with CRC-15 check and ACK.
// Revision : 1.0 - initial release
// ============================================================================
module can_frame_rx
    import can_pkg::*;
#(
    parameter int          BIT_CLKS  = 100,
    parameter int          SAMPLE_PT = 50,
    parameter logic [14:0] CRC_POLY  = CRC_POLY_CAN
) (
    input  logic           clk,
    input  logic           n_rst,
    can_frame_rx_if.master bus
);

    localparam int               CNT_W       = $clog2(BIT_CLKS);
    localparam logic [CNT_W-1:0] C_SAMPLE    = CNT_W'(SAMPLE_PT);
    localparam logic [CNT_W-1:0] C_LAST      = CNT_W'(BIT_CLKS - 1);
    localparam logic [5:0]       C_ID_LAST   = 6'(ID_BITS - 1);
    localparam logic [5:0]       C_CTRL_LAST = 6'(CTRL_BITS - 1);
    localparam logic [5:0]       C_DATA_LAST = 6'(DATA_BITS - 1);
    localparam logic [5:0]       C_CRC_LAST  = 6'(CRC_BITS - 1);

    can_rx_state_t        r_state;
    can_rx_state_t        w_next_state;

    logic                 r_sync1;
    logic                 r_rx_s;
    logic                 r_rx_s_prev;
    logic [CNT_W-1:0]     r_clk_cnt;
    logic [5:0]           r_bit_cnt;
    logic [ID_BITS-1:0]   r_rx_id;
    logic [CTRL_BITS-1:0] r_rx_ctrl;
    logic [DATA_BITS-1:0] r_rx_data;
    logic [CRC_BITS-2:0]  r_crc_rx;
    logic                 r_crc_ok;
    logic                 r_rx_valid;
    logic                 r_rx_error;
    logic                 r_can_tx;

    logic                 w_fall;
    logic                 w_samp_pt;
    logic                 w_boundary;
    logic                 w_field_last;
    logic                 w_busy;
    logic                 w_crc_clear;
    logic                 w_crc_shift;
    logic                 w_crc_din;
    logic                 w_set_valid;
    logic                 w_set_error;
    logic                 w_can_tx;
    logic [CRC_BITS-1:0]  w_crc_calc;

    assign w_fall     = r_rx_s_prev & ~r_rx_s;
    assign w_samp_pt  = (r_clk_cnt == C_SAMPLE);
    assign w_boundary = (r_clk_cnt == C_LAST);

    // Single-bit states (SOF/ACK/EOF) finish their field at every boundary.
    always_comb begin
        case (r_state)
            ARB:     w_field_last = (r_bit_cnt == C_ID_LAST);
            CTRL:    w_field_last = (r_bit_cnt == C_CTRL_LAST);
            DATA:    w_field_last = (r_bit_cnt == C_DATA_LAST);
            CRC:     w_field_last = (r_bit_cnt == C_CRC_LAST);
            default: w_field_last = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: if (w_fall) w_next_state = SOF;
            SOF: begin
                if (w_samp_pt && r_rx_s)  w_next_state = IDLE;
                else if (w_boundary)      w_next_state = ARB;
            end
            ARB:  if (w_boundary && w_field_last) w_next_state = CTRL;
            CTRL: if (w_boundary && w_field_last) w_next_state = DATA;
            DATA: if (w_boundary && w_field_last) w_next_state = CRC;
            CRC:  if (w_boundary && w_field_last) w_next_state = ACK;
            ACK:  if (w_boundary) w_next_state = r_crc_ok ? EOF : IDLE;
            EOF:  if (w_samp_pt)  w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        w_busy      = (r_state != IDLE);
        w_crc_clear = (r_state == IDLE) && w_fall;
        w_crc_shift = 1'b0;
        w_crc_din   = r_rx_s;
        w_set_valid = 1'b0;
        w_set_error = 1'b0;
        case (r_state)
            SOF: begin
                if (w_samp_pt) begin
                    w_set_error = r_rx_s;
                    w_crc_shift = ~r_rx_s;
                    w_crc_din   = 1'b0;
                end
            end
            ARB, CTRL, DATA: w_crc_shift = w_samp_pt;
            ACK:  w_set_error = w_samp_pt && !r_crc_ok;
            EOF: begin
                w_set_valid = w_samp_pt && r_rx_s && r_crc_ok;
                w_set_error = w_samp_pt && !r_rx_s;
            end
            default: ;
        endcase
        // Drive dominant for exactly the cycles the FSM spends in ACK.
        w_can_tx = !((w_next_state == ACK) && r_crc_ok);
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_sync1     <= 1'b1;
            r_rx_s      <= 1'b1;
            r_rx_s_prev <= 1'b1;
            r_clk_cnt   <= '0;
            r_bit_cnt   <= '0;
            r_rx_id     <= '0;
            r_rx_ctrl   <= '0;
            r_rx_data   <= '0;
            r_crc_rx    <= '0;
            r_crc_ok    <= 1'b0;
            r_rx_valid  <= 1'b0;
            r_rx_error  <= 1'b0;
            r_can_tx    <= 1'b1;
        end else begin
            r_sync1     <= bus.can_rx;
            r_rx_s      <= r_sync1;
            r_rx_s_prev <= r_rx_s;

            // The falling-edge cycle counts as clk_cnt 0 of the SOF bit.
            if (r_state == IDLE) begin
                r_clk_cnt <= w_fall ? CNT_W'(1) : '0;
            end else if (w_boundary || (w_next_state == IDLE)) begin
                r_clk_cnt <= '0;
            end else begin
                r_clk_cnt <= r_clk_cnt + 1'b1;
            end

            if (r_state == IDLE) begin
                r_bit_cnt <= '0;
            end else if (w_boundary) begin
                r_bit_cnt <= w_field_last ? 6'd0 : r_bit_cnt + 6'd1;
            end

            if (w_samp_pt) begin
                case (r_state)
                    ARB:  r_rx_id   <= {r_rx_id[ID_BITS-2:0], r_rx_s};
                    CTRL: r_rx_ctrl <= {r_rx_ctrl[CTRL_BITS-2:0], r_rx_s};
                    DATA: r_rx_data <= {r_rx_data[DATA_BITS-2:0], r_rx_s};
                    CRC: begin
                        r_crc_rx <= {r_crc_rx[CRC_BITS-3:0], r_rx_s};
                        if (w_field_last) begin
                            r_crc_ok <= ({r_crc_rx, r_rx_s} == w_crc_calc);
                        end
                    end
                    default: ;
                endcase
            end

            if (w_crc_clear) begin
                r_crc_ok <= 1'b0;
            end

            r_rx_valid <= w_set_valid;
            r_rx_error <= w_set_error;
            r_can_tx   <= w_can_tx;
        end
    end

    can_crc15 #(
        .POLY     (CRC_POLY)
    ) u_crc (
        .clk      (clk),
        .n_rst    (n_rst),
        .clear    (w_crc_clear),
        .shift_en (w_crc_shift),
        .din      (w_crc_din),
        .crc      (w_crc_calc)
    );

    assign bus.can_tx   = r_can_tx;
    assign bus.rx_id    = r_rx_id;
    assign bus.rx_ctrl  = r_rx_ctrl;
    assign bus.rx_data  = r_rx_data;
    assign bus.rx_valid = r_rx_valid;
    assign bus.rx_error = r_rx_error;
    assign bus.busy     = w_busy;

endmodule
`default_nettype wire
